// File: rtl/output_streamer_if.sv
// Bus bundle for output_streamer: start/status, SRAM read port and pixel stream.
// The master modport is the streamer; the slave modport is the surrounding system
// (top-level controller, SRAM and the downstream pixel consumer).
interface output_streamer_if #(
    parameter int ADDR_SIZE_BITS  = 24,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64
);
    logic                                         stream_en;
    logic                                         busy;
    logic                                         stream_done;
    logic                                         read_enable;
    logic [ADDR_SIZE_BITS-1:0]                    address;
    logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data;
    logic [WORD_SIZE_BYTES*8-1:0]                 pixel_data;
    logic                                         pixel_valid;
    logic                                         pixel_ready;
    logic                                         frame_first;

    modport master (
        input  stream_en, read_data, pixel_ready,
        output busy, stream_done, read_enable, address,
               pixel_data, pixel_valid, frame_first
    );

    modport slave (
        output stream_en, read_data, pixel_ready,
        input  busy, stream_done, read_enable, address,
               pixel_data, pixel_valid, frame_first
    );
endinterface

// File: rtl/output_streamer.sv
// output_streamer: reads the blended frame out of the SRAM output buffer one
// 64-pixel block at a time into a pair of ping-pong block buffers and drains
// them as a gap-free valid/ready stream of 24-bit pixels.
module output_streamer #(
    parameter int ADDR_SIZE_BITS  = 24,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64,
    parameter int BASE_ADDR       = 143360,
    parameter int NUM_BLOCKS      = 1024
) (
    input logic                clk,
    input logic                n_rst,
    output_streamer_if.master  bus
);
    localparam int BUF_BITS   = WORD_SIZE_BYTES * DATA_SIZE_WORDS * 8;
    localparam int PIXEL_BITS = WORD_SIZE_BYTES * 8;
    localparam int BLK_BITS   = $clog2(NUM_BLOCKS + 1);
    localparam int PIX_BITS   = $clog2(DATA_SIZE_WORDS);
    localparam int FRAME_BITS = $clog2(NUM_BLOCKS * DATA_SIZE_WORDS);

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_CAP,
        F_DRAIN
    } fetch_state_t;

    fetch_state_t          state;
    logic [BUF_BITS-1:0]   blk_buf [2];
    logic [1:0]            full;
    logic                  wr_sel;
    logic [BLK_BITS-1:0]   blk;
    logic                  rd_sel;
    logic [PIX_BITS-1:0]   pix;
    logic [FRAME_BITS-1:0] frame_pix;

    logic start;
    logic fetch_req;
    logic capture;
    logic pix_valid;
    logic transfer;
    logic last_pix;

    assign start     = (state == F_IDLE) && bus.stream_en;
    assign fetch_req = (state == F_REQ) && (blk != BLK_BITS'(NUM_BLOCKS)) && !full[wr_sel];
    assign capture   = (state == F_CAP);
    assign pix_valid = full[rd_sel];
    assign transfer  = pix_valid && bus.pixel_ready;
    assign last_pix  = (pix == PIX_BITS'(DATA_SIZE_WORDS - 1));

    // Fetch FSM: request one block whenever the buffer it targets is free, until the frame is fetched
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= F_IDLE;
            blk    <= '0;
            wr_sel <= 1'b0;
        end else begin
            case (state)
                F_IDLE: begin
                    if (bus.stream_en) begin
                        state  <= F_REQ;
                        blk    <= '0;
                        wr_sel <= 1'b0;
                    end
                end
                F_REQ: begin
                    if (blk == BLK_BITS'(NUM_BLOCKS)) begin
                        state <= F_DRAIN;
                    end else if (!full[wr_sel]) begin
                        state <= F_CAP;
                    end
                end
                F_CAP: begin
                    blk    <= blk + 1'b1;
                    wr_sel <= ~wr_sel;
                    state  <= F_REQ;
                end
                F_DRAIN: begin
                    if (full == 2'b00) begin
                        state <= F_IDLE;
                    end
                end
                default: state <= F_IDLE;
            endcase
        end
    end

    // Block storage: the SRAM answers one cycle after the request, which is the capture cycle
    always_ff @(posedge clk) begin
        if (capture) begin
            blk_buf[wr_sel] <= bus.read_data;
        end
    end

    // Stream side: buffer occupancy, read pointers and frame pixel position
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            full      <= 2'b00;
            rd_sel    <= 1'b0;
            pix       <= '0;
            frame_pix <= '0;
        end else if (start) begin
            full      <= 2'b00;
            rd_sel    <= 1'b0;
            pix       <= '0;
            frame_pix <= '0;
        end else begin
            if (capture) begin
                full[wr_sel] <= 1'b1;
            end
            if (transfer) begin
                frame_pix <= frame_pix + 1'b1;
                if (last_pix) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                    pix          <= '0;
                end else begin
                    pix <= pix + 1'b1;
                end
            end
        end
    end

    // Output decode: SRAM address is forced to zero outside read strobes, pixel data to zero when not valid
    always_comb begin
        bus.busy        = (state != F_IDLE);
        bus.stream_done = (state == F_DRAIN) && (full == 2'b00);
        bus.read_enable = fetch_req;
        bus.address     = '0;
        if (fetch_req) begin
            bus.address = ADDR_SIZE_BITS'(BASE_ADDR)
                        + ADDR_SIZE_BITS'(blk) * ADDR_SIZE_BITS'(DATA_SIZE_WORDS);
        end
        bus.pixel_valid = pix_valid;
        bus.frame_first = pix_valid && (frame_pix == '0);
        bus.pixel_data  = '0;
        if (pix_valid) begin
            bus.pixel_data = blk_buf[rd_sel][int'(pix) * PIXEL_BITS +: PIXEL_BITS];
        end
    end
endmodule
